// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring shift-subtract
// step per cycle, fixed 33-cycle latency from the accept edge to the o_valid pulse.
module mdu_iter #(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [2:0]      i_funct3,
   input  logic [XLEN-1:0] i_dataa,
   input  logic [XLEN-1:0] i_datab,
   input  logic            i_flush,
   output logic            o_valid,
   output logic [XLEN-1:0] o_datac,
   output logic [1:0]      fsm_state
);

   localparam int CW = $clog2(XLEN) + 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [2:0] F_MUL    = 3'd0;
   localparam logic [2:0] F_MULH   = 3'd1;
   localparam logic [2:0] F_MULHSU = 3'd2;
   localparam logic [2:0] F_MULHU  = 3'd3;
   localparam logic [2:0] F_DIV    = 3'd4;
   localparam logic [2:0] F_REM    = 3'd6;

   // Handshake: a request is taken on a rising edge where i_valid=1, o_ready=1
   // and i_flush=0; o_valid is a one-cycle pulse that needs no acknowledgement.

   logic [1:0]        state;
   logic [2:0]        fn;
   logic [XLEN-1:0]   op;
   logic [2*XLEN-1:0] work;
   logic [CW-1:0]     cnt;
   logic              neg;
   logic [XLEN-1:0]   datac;

   logic              signed_a;
   logic              signed_b;
   logic              a_neg;
   logic              b_neg;
   logic              b_zero;
   logic              neg_in;
   logic [XLEN-1:0]   mag_a;
   logic [XLEN-1:0]   mag_b;

   always_comb begin
      signed_a = (i_funct3 == F_MULH) || (i_funct3 == F_MULHSU) ||
                 (i_funct3 == F_DIV)  || (i_funct3 == F_REM);
      signed_b = (i_funct3 == F_MULH) || (i_funct3 == F_DIV) || (i_funct3 == F_REM);
      a_neg    = signed_a & i_dataa[XLEN-1];
      b_neg    = signed_b & i_datab[XLEN-1];
      mag_a    = a_neg ? -i_dataa : i_dataa;
      mag_b    = b_neg ? -i_datab : i_datab;
      b_zero   = (i_datab == '0);
      // Divide by zero keeps an all-ones quotient, so its sign is never flipped.
      case (i_funct3)
         F_DIV:   neg_in = (a_neg ^ b_neg) & ~b_zero;
         F_REM:   neg_in = a_neg;
         default: neg_in = a_neg ^ b_neg;
      endcase
   end

   // Multiply keeps {partial_hi, multiplier} in work; divide keeps {remainder, dividend/quotient}.
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     rem_sh;
   logic [XLEN:0]     rem_diff;
   logic [2*XLEN-1:0] mul_next;
   logic [2*XLEN-1:0] div_next;
   logic [2*XLEN-1:0] step;

   always_comb begin
      mul_sum  = {1'b0, work[2*XLEN-1:XLEN]} + (work[0] ? {1'b0, op} : '0);
      mul_next = {mul_sum, work[XLEN-1:1]};
      rem_sh   = work[2*XLEN-1:XLEN-1];
      rem_diff = rem_sh - {1'b0, op};
      div_next = rem_diff[XLEN] ? {rem_sh[XLEN-1:0], work[XLEN-2:0], 1'b0}
                                : {rem_diff[XLEN-1:0], work[XLEN-2:0], 1'b1};
      step     = fn[2] ? div_next : mul_next;
   end

   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   div_raw;
   logic [XLEN-1:0]   result;

   always_comb begin
      prod_fix = neg ? -step : step;
      div_raw  = fn[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
      case (fn)
         F_MUL:                     result = prod_fix[XLEN-1:0];
         F_MULH, F_MULHSU, F_MULHU: result = prod_fix[2*XLEN-1:XLEN];
         default:                   result = neg ? -div_raw : div_raw;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state <= IDLE;
         fn    <= '0;
         op    <= '0;
         work  <= '0;
         cnt   <= '0;
         neg   <= 1'b0;
         datac <= '0;
      end else if (i_flush) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (i_valid) begin
                  fn    <= i_funct3;
                  op    <= i_funct3[2] ? mag_b : mag_a;
                  work  <= {{XLEN{1'b0}}, (i_funct3[2] ? mag_a : mag_b)};
                  cnt   <= '0;
                  neg   <= neg_in;
                  state <= BUSY;
               end
            end
            BUSY: begin
               work <= step;
               cnt  <= cnt + CW'(1);
               if (cnt == CW'(XLEN - 1)) begin
                  datac <= result;
                  state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign o_ready   = (state == IDLE);
   assign o_valid   = (state == DONE) & ~i_flush;
   assign o_datac   = datac;
   assign fsm_state = state;

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: drivers push expected results into a queue, a negedge
// monitor pops and checks value and latency on every o_valid pulse.
module tb_mdu_iter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [31:0] dataa = '0;
   logic [31:0] datab = '0;
   logic        ready;
   logic        res_valid;
   logic [31:0] datac;
   logic [1:0]  fsm_state;

   int          cyc = 0;
   int          n_vec = 0;
   int          n_chk = 0;
   int          n_fail = 0;
   int          n_valid = 0;
   logic [31:0] held = '0;
   logic [31:0] exp_q[$];
   int          due_q[$];

   mdu_iter dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_valid   (valid),
      .o_ready   (ready),
      .i_funct3  (funct3),
      .i_dataa   (dataa),
      .i_datab   (datab),
      .i_flush   (flush),
      .o_valid   (res_valid),
      .o_datac   (datac),
      .fsm_state (fsm_state)
   );

   // clock / cycle count
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // reference model: plain 64-bit / integer arithmetic on the RISC-V M rules
   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] sa, sb, ua, ub, p;
      int ia, ib, iq;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'd0, a};
      ub = {32'd0, b};
      ia = $signed(a);
      ib = $signed(b);
      p  = '0;
      iq = 0;
      model = '0;
      case (f)
         3'd0: begin p = ua * ub; model = p[31:0];  end
         3'd1: begin p = sa * sb; model = p[63:32]; end
         3'd2: begin p = sa * ub; model = p[63:32]; end
         3'd3: begin p = ua * ub; model = p[63:32]; end
         3'd4: begin
            if (b == 0) model = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = 32'h8000_0000;
            else begin iq = ia / ib; model = iq; end
         end
         3'd5: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) model = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = '0;
            else begin iq = ia % ib; model = iq; end
         end
         default: model = (b == 0) ? a : a % b;
      endcase
   endfunction

   // monitor / scoreboard
   always @(negedge clk) begin : monitor
      logic [31:0] e;
      int          d;
      if (!rst_n) begin
         held = '0;
      end else if (res_valid) begin
         n_valid++;
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_valid: got o_valid=1, expected 0 (cycle %0d)", cyc);
         end else begin
            e = exp_q.pop_front();
            d = due_q.pop_front();
            chk("result", datac, e);
            chk("latency", cyc, d);
            held = e;
         end
      end
   end

   // drivers
   task automatic wait_ready();
      int n = 0;
      @(negedge clk);
      while (!ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!ready) chk("ready_timeout", {31'd0, ready}, 32'd1);
   endtask

   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, output int acc);
      wait_ready();
      funct3 = f;
      dataa  = a;
      datab  = b;
      valid  = 1'b1;
      exp_q.push_back(exp);
      due_q.push_back(cyc + 33);
      acc = cyc + 1;
      n_vec++;
      @(negedge clk);
      valid  = 1'b0;
      funct3 = 3'($urandom_range(0, 7));
      dataa  = $urandom;
      datab  = $urandom;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain", exp_q.size(), 32'd0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       pick = 32'd0;
         1:       pick = 32'h8000_0000;
         2:       pick = 32'hFFFF_FFFF;
         default: pick = $urandom;
      endcase
   endfunction

   logic [2:0]  d_f[12]   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7,
                              3'd4, 3'd7, 3'd6, 3'd5, 3'd4};
   logic [31:0] d_a[12]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                              32'hFFFF_FFF9, 32'd100, 32'd100, 32'h1234_5678, 32'h1234_5678,
                              32'h8000_0000, 32'h1234_5678, 32'h8000_0000};
   logic [31:0] d_b[12]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                              32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF};
   logic [31:0] d_exp[12] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD,
                              32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'h1234_5678,
                              32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000};

   initial begin : main
      int acc;
      int acc_list[$];
      int n;
      int saved;
      logic [31:0] a, b;
      logic [2:0]  f;

      // reset
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("reset_ready", {31'd0, ready}, 32'd1);
      chk("reset_valid", {31'd0, res_valid}, 32'd0);
      chk("reset_datac", datac, 32'd0);
      chk("reset_state", {30'd0, fsm_state}, 32'd0);

      // MUL 7*6 with o_ready profile over cycles 1..34
      issue(3'd0, 32'd7, 32'd6, 32'd42, acc);
      for (int j = 1; j <= 34; j++) begin
         if (j > 1) @(negedge clk);
         chk($sformatf("ready_cycle%0d", j), {31'd0, ready}, (j == 34) ? 32'd1 : 32'd0);
      end

      // directed corner cases
      for (int i = 0; i < 12; i++) issue(d_f[i], d_a[i], d_b[i], d_exp[i], acc);

      // random operations against the model
      for (int i = 0; i < 40; i++) begin
         f = 3'($urandom_range(0, 7));
         a = pick();
         b = pick();
         issue(f, a, b, model(f, a, b), acc);
      end

      // i_valid held high with operands changing every cycle
      drain();
      acc_list.delete();
      n = 0;
      while (acc_list.size() < 2 && n < 200) begin
         @(negedge clk);
         f = 3'($urandom_range(0, 7));
         a = pick();
         b = pick();
         funct3 = f;
         dataa  = a;
         datab  = b;
         valid  = 1'b1;
         if (ready) begin
            exp_q.push_back(model(f, a, b));
            due_q.push_back(cyc + 33);
            acc_list.push_back(cyc + 1);
            n_vec++;
         end
         n++;
      end
      @(negedge clk);
      valid = 1'b0;
      if (acc_list.size() == 2) chk("accept_spacing", acc_list[1] - acc_list[0], 32'd34);
      else chk("accept_count", acc_list.size(), 32'd2);

      // flush and valid together in IDLE: nothing accepted
      drain();
      wait_ready();
      funct3 = 3'd0;
      dataa  = $urandom;
      datab  = $urandom;
      valid  = 1'b1;
      flush  = 1'b1;
      @(negedge clk);
      chk("flush_idle_ready", {31'd0, ready}, 32'd1);
      chk("flush_idle_state", {30'd0, fsm_state}, 32'd0);
      valid = 1'b0;
      flush = 1'b0;
      saved = n_valid;
      repeat (40) @(negedge clk);
      chk("flush_idle_no_valid", n_valid, saved);

      // flush at BUSY cycle 10
      issue(3'd0, 32'd7, 32'd6, 32'd42, acc);
      drain();
      a = $urandom;
      b = $urandom_range(1, 1000);
      issue(3'd5, a, b, model(3'd5, a, b), acc);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      void'(exp_q.pop_back());
      void'(due_q.pop_back());
      saved = n_valid;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_ready", {31'd0, ready}, 32'd1);
      chk("flush_datac", datac, held);
      chk("flush_state", {30'd0, fsm_state}, 32'd0);
      repeat (40) @(negedge clk);
      chk("flush_no_valid", n_valid, saved);

      // reset at BUSY cycle 10
      a = $urandom;
      b = $urandom_range(1, 1000);
      issue(3'd5, a, b, model(3'd5, a, b), acc);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      void'(exp_q.pop_back());
      void'(due_q.pop_back());
      saved = n_valid;
      @(negedge clk);
      rst_n = 1'b1;
      chk("midrst_ready", {31'd0, ready}, 32'd1);
      chk("midrst_datac", datac, 32'd0);
      chk("midrst_state", {30'd0, fsm_state}, 32'd0);
      repeat (40) @(negedge clk);
      chk("midrst_no_valid", n_valid, saved);

      // a normal operation still works after the abort
      issue(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, acc);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative RV32M multiply/divide unit.
- Sits beside ALU_rtr in the execute stage and takes the same i_dataa/i_datab operand pair.
- Decodes the M-extension funct3 (funct7=0000001) and produces one 32-bit result per operation with a fixed multi-cycle latency.
- Uses a valid/ready handshake so the pipeline stalls while the unit is busy.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported. Iteration counter width is clog2(XLEN)+1.

Ports:
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  synchronous active-low reset
- i_valid  input  1  operation request
- o_ready  output  1  unit idle, can accept a request
- i_funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- i_dataa  input  32  rs1 operand
- i_datab  input  32  rs2 operand
- i_flush  input  1  abort any in-flight operation
- o_valid  output  1  result valid, one-cycle pulse
- o_datac  output  32  result

Behaviour:
- Reset, sampled on a rising edge with i_rst_n=0: state IDLE, o_ready=1, o_valid=0, o_datac=0, all internal registers cleared. This applies mid-operation; the in-flight operation is lost.
- States: IDLE, BUSY, DONE.
- IDLE:
  - o_ready=1.
  - On an edge with i_valid=1, latch funct3 and operands, clear the counter, go to BUSY. Edge k is the accept edge.
  - Signed ops (MULH, DIV, REM) and MULHSU's rs1 are converted to magnitude; the result sign is recorded.
- BUSY:
  - o_ready=0; i_valid is ignored.
  - One iteration per cycle; 32 iterations.
  - Multiply: shift-add into a 64-bit product.
  - Divide: restoring shift-subtract producing a 32-bit quotient and remainder.
  - On the edge that completes iteration 32 (edge k+32), apply sign correction and load o_datac, go to DONE.
- DONE:
  - o_valid=1 for exactly one cycle (the cycle after edge k+32), o_ready=0.
  - Next edge returns to IDLE.
  - Back-to-back: a new request is accepted at the earliest on edge k+34.
- Latency is fixed at 33 cycles from the accept edge to o_valid, independent of operand values, including special cases.
- Result selection:
  - MUL: low 32 bits of the product.
  - MULH, MULHSU, MULHU: high 32 bits of the signed×signed, signed×unsigned and unsigned×unsigned product respectively.
  - DIV, DIVU: quotient.
  - REM, REMU: remainder.
  - Remainder takes the sign of the dividend. Signed quotient is truncated toward zero.
- Divide by zero (rs2=0):
  - DIV/DIVU quotient = 32'hFFFFFFFF.
  - REM/REMU = rs1.
  - No exception.
- Signed overflow (DIV/REM with rs1=32'h80000000, rs2=32'hFFFFFFFF):
  - DIV = 32'h80000000.
  - REM = 0.
- o_datac holds its last value until the next DONE load. It is not cleared when returning to IDLE.
- i_flush=1 on any edge (reset not asserted):
  - Next state IDLE, o_valid=0; o_datac unchanged.
  - Flush in DONE suppresses the o_valid pulse.
  - If i_flush and i_valid are both high in IDLE, the flush wins and nothing is accepted.
- Operands and funct3 are sampled only at the accept edge. Changes during BUSY have no effect.

Test Plan:
1. Reset then MUL: rs1=7, rs2=6 -> o_valid exactly 33 cycles after the accept edge, o_datac=42; o_ready low for cycles 1..33, high again on cycle 34.
2. MULH/MULHSU/MULHU with rs1=32'hFFFFFFFF, rs2=32'hFFFFFFFF -> 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFE respectively.
3. DIV rs1=-7 (32'hFFFFFFF9), rs2=2 -> 32'hFFFFFFFD (-3); REM same operands -> 32'hFFFFFFFF (-1); DIVU 100/7 -> 14; REMU 100/7 -> 2.
4. Divide by zero, rs1=32'h12345678, rs2=0: DIV -> 32'hFFFFFFFF, REMU -> 32'h12345678. Overflow: DIV 32'h80000000 / 32'hFFFFFFFF -> 32'h80000000, REM -> 0; latency still 33.
5. Start DIVU, then assert i_flush at BUSY cycle 10 -> o_ready=1 next cycle, no o_valid pulse, o_datac keeps its previous value. Repeat with i_rst_n=0 at BUSY cycle 10 -> o_datac=0, IDLE.
6. Hold i_valid high continuously with changing operands during BUSY -> only the operands at the accept edge are used; second accept at edge k+34; two o_valid pulses spaced 34 cycles apart.
